// File: rtl/noise_sequencer.sv
// rtl/noise_sequencer.sv - APU noise channel period/mode register, period counter and LFSR
//
// Purpose: holds the noise period/mode register. It counts down from the decoded period on
// APU-enabled cycles and shifts a 15-bit LFSR on every counter underflow.
//
// Ports:
//   CLK      in   system clock, all state on rising edge
//   RES      in   synchronous active-high reset
//   ACLK_EN  in   APU-cycle enable, counter/LFSR advance only when 1
//   WR       in   write strobe for the period/mode register
//   DIN      in   write data: [7] mode, [3:0] period index
//   NF       out  registered period index to the external decoder
//   NNF      in   decoded reload value (combinational from NF)
//   MODE     out  registered mode bit (selects feedback tap 6 instead of tap 1)
//   LFSR     out  shift register state
//   RND      out  random bit, LFSR[0]
//   STEP     out  pulse in every cycle the LFSR shifts
module noise_sequencer #(
  parameter int unsigned CNT_W     = 11,
  parameter logic [14:0] LFSR_INIT = 15'h0001
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             ACLK_EN,
  input  logic             WR,
  input  logic [7:0]       DIN,
  output logic [3:0]       NF,
  input  logic [CNT_W-1:0] NNF,
  output logic             MODE,
  output logic [14:0]      LFSR,
  output logic             RND,
  output logic             STEP
);

  typedef enum logic {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       nf_q, nf_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [14:0]      lfsr_q, lfsr_d;
  logic             step;
  logic             fb;

  // DIN[6:4] carry no function in this register.
  logic unused_din;
  assign unused_din = ^DIN[6:4];

  always_comb begin
    state_d = state_q;
    nf_d    = nf_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    step    = 1'b0;
    fb      = lfsr_q[0] ^ (mode_q ? lfsr_q[6] : lfsr_q[1]);

    // RESET is left on the first cycle without RES; RES forces it back in the register.
    case (state_q)
      S_RESET: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    // Register write never touches the counter; the new index only matters at the next reload.
    if (WR) begin
      nf_d   = DIN[3:0];
      mode_d = DIN[7];
    end

    // Reload and step use the current (pre-write) NF/MODE because both update at this edge.
    if (ACLK_EN && !RES) begin
      if (cnt_q == '0) begin
        step  = 1'b1;
        cnt_d = NNF;
        // All-zero state would lock the LFSR forever; re-seed instead of shifting.
        lfsr_d = (lfsr_q == '0) ? 15'h0001 : {fb, lfsr_q[14:1]};
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= S_RESET;
      nf_q    <= 4'h0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_INIT;
    end else begin
      state_q <= state_d;
      nf_q    <= nf_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign NF   = nf_q;
  assign MODE = mode_q;
  assign LFSR = lfsr_q;
  assign RND  = lfsr_q[0];
  assign STEP = step;

endmodule

// File: tb/tb_noise_sequencer.sv
// tb/tb_noise_sequencer.sv - self-checking bench for noise_sequencer
//
// Purpose: drives directed and random register writes, enables and resets. The bench decodes NF
// to NNF from its own table and compares every cycle against a behavioural model.
// Ports: none (top-level bench).
module tb_noise_sequencer;

  logic        CLK = 1'b0;
  logic        RES, ACLK_EN, WR;
  logic [7:0]  DIN;
  logic [3:0]  NF;
  logic [10:0] NNF;
  logic        MODE;
  logic [14:0] LFSR;
  logic        RND, STEP;

  always #5 CLK = ~CLK;

  // Bench-side period decoder.
  int nnf_tab[16] = '{2, 0, 1, 3, 5, 7, 10, 15, 20, 31, 50, 63, 100, 127, 255, 2033};
  assign NNF = 11'(nnf_tab[NF]);

  noise_sequencer #(.CNT_W(11), .LFSR_INIT(15'h0001)) dut (
    .CLK(CLK), .RES(RES), .ACLK_EN(ACLK_EN), .WR(WR), .DIN(DIN),
    .NF(NF), .NNF(NNF), .MODE(MODE), .LFSR(LFSR), .RND(RND), .STEP(STEP)
  );

  int errors = 0;
  int checks = 0;

  // Model state: enabled ticks left before the next step, plus register and LFSR values.
  int m_nf, m_mode, m_wait, m_lfsr;
  int last_step;
  int cyc_n = 0;

  function automatic int lfsr_next(int x, int mode);
    int tap;
    tap = (mode != 0) ? 6 : 1;
    if (x == 0) return 1;
    return (x >> 1) | (((x ^ (x >> tap)) & 1) << 14);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_nf = 0; m_mode = 0; m_wait = 0; m_lfsr = 1;
  endtask

  // One clock: apply inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic res, input logic en, input logic wr, input logic [7:0] din);
    int exp_step;
    cyc_n++;
    RES = res; ACLK_EN = en; WR = wr; DIN = din;
    @(negedge CLK);
    exp_step = (!res && en && m_wait == 0) ? 1 : 0;
    check("nf", int'(NF), m_nf);
    check("mode", int'(MODE), m_mode);
    check("lfsr", int'(LFSR), m_lfsr);
    check("rnd", int'(RND), m_lfsr & 1);
    check("step", int'(STEP), exp_step);
    last_step = int'(STEP);
    @(posedge CLK);
    if (res) begin
      model_reset();
    end else begin
      if (en) begin
        if (m_wait == 0) begin
          m_wait = nnf_tab[m_nf];
          m_lfsr = lfsr_next(m_lfsr, m_mode);
        end else begin
          m_wait = m_wait - 1;
        end
      end
      if (wr) begin
        m_nf   = int'(din[3:0]);
        m_mode = int'(din[7]);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_step(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      if (last_step != 0) begin
        at = cyc_n;
        break;
      end
    end
    if (at < 0) check("wait_step_timeout", 0, 1);
  endtask

  initial begin
    int t0, t1, t2, n;
    int steps_at[$];

    RES = 1'b1; ACLK_EN = 1'b0; WR = 1'b0; DIN = 8'h00;
    @(posedge CLK);
    #1;
    model_reset();

    // Reset values and first step.
    do_reset();
    check("rst_step", last_step, 0);
    check("rst_lfsr", int'(LFSR), 15'h0001);
    check("rst_rnd", int'(RND), 1);
    check("rst_nf", int'(NF), 0);
    check("rst_mode", int'(MODE), 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("first_step", last_step, 1);
    check("lfsr_4000", int'(LFSR), 15'h4000);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("no_step_2", last_step, 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("step_3rd", last_step, 1);
    check("lfsr_2000", int'(LFSR), 15'h2000);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("lfsr_1000", int'(LFSR), 15'h1000);

    // ACLK_EN toggling: one step every 6 clocks.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 8'h00);
      if (last_step != 0) steps_at.push_back(cyc_n);
    end
    check("toggle_steps", steps_at.size(), 2);
    if (steps_at.size() == 2) check("toggle_spacing", steps_at[1] - steps_at[0], 6);

    // Reset mid-count, with a write pending in the same window.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h83);
    cyc(1'b1, 1'b1, 1'b1, 8'h05);
    check("midrst_lfsr", int'(LFSR), 15'h0001);
    check("midrst_nf", int'(NF), 0);
    check("midrst_mode", int'(MODE), 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("midrst_cnt0_step", last_step, 1);

    // Period change mid-count: old period finishes, then 2034-cycle interval.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    t0 = cyc_n;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'h0F);
    wait_step(10, t1);
    check("mid_old_interval", t1 - t0, 3);
    wait_step(2100, t2);
    check("mid_new_interval", t2 - t1, 2034);

    // Write landing on the reload cycle: reload still uses the old NNF of 2.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 8'h0F);
    check("wr_on_reload_step", last_step, 1);
    t0 = cyc_n;
    wait_step(10, t1);
    check("wr_on_reload_interval", t1 - t0, 3);
    wait_step(2100, t2);
    check("wr_on_reload_next", t2 - t1, 2034);

    // Write without enable leaves the count untouched.
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 8'h01);
    check("wr_noen_nf", int'(NF), 1);
    check("wr_noen_lfsr", int'(LFSR), 15'h0001);

    // MODE=1 sequence length (NF=1 decodes to 0, so one step per enabled cycle).
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 8'h81);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      if (last_step != 0) n++;
      if (LFSR == 15'h0001) break;
    end
    check("mode1_period", n, 93);

    // MODE=0 full-length sequence.
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 8'h01);
    n = 0;
    for (int i = 0; i < 40000; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      if (last_step != 0) n++;
      if (LFSR == 15'h0001) break;
    end
    check("mode0_period", n, 32767);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic r, e, w;
      logic [7:0] d;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 24) == 0);
      d = 8'($urandom);
      if (d[3:0] == 4'hF) d[3:0] = 4'h1;
      cyc(r, e, w, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
